seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Parametrised, time-multiplexed driver for an N-digit common-anode 7-segment display. It scans digits at a programmable rate and decodes full hex (0-F) per digit. It adds per-digit decimal point, per-digit blink and an enable. Input values are snapshotted once per scan frame so the display never tears. Sits between board-level display pins and any value-producing logic.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
DIGIT_TICKS, 100000, CLK cycles each digit stays lit (1 ms at 100 MHz); must be >= 2
BLINK_FRAMES, 250, frames per blink half-period; must be >= 1

Ports:
CLK  input  1  system clock, rising edge
RST_N  input  1  asynchronous, active-low reset
EN  input  1  1 = display on; 0 = all dark, scan keeps running
VALUE  input  4*NUM_DIGITS  hex nibbles; digit k = VALUE[4k+3:4k], k=0 rightmost
DP  input  NUM_DIGITS  DP[k]=1 lights decimal point of digit k
BLINK  input  NUM_DIGITS  BLINK[k]=1 makes digit k blink
DISP  output  NUM_DIGITS+8  {anodes[NUM_DIGITS-1:0], seg a..g, dp}; all active-low; anode of digit k = DISP[8+k]; a = DISP[7] … g = DISP[1]; dp = DISP[0]
FRAME  output  1  one-cycle pulse at the start of each scan frame

Behaviour:
- Reset (async, immediate, no clock needed): tick counter=0, digit pointer=NUM_DIGITS-1, snapshot VALUE/DP/BLINK=0, blink frame counter=0, blink phase=0, DISP=all ones, FRAME=0.
- Tick counter counts 0..DIGIT_TICKS-1 and wraps. At terminal count the pointer steps k→k-1. Scan order is leftmost (NUM_DIGITS-1) down to 0, then wraps to NUM_DIGITS-1.
- On the pointer wrap 0→NUM_DIGITS-1:
  - VALUE, DP and BLINK are captured into snapshot registers.
  - FRAME=1 for exactly that cycle.
  - Blink frame counter increments. When it reaches BLINK_FRAMES-1 it clears and blink phase toggles.
- DISP is registered. It is a function of (pointer, snapshots, blink phase, EN) with 1-cycle latency.
- Lit digit k: anode bit k=0, all other anodes 1.
  - Segments a..g from the hex table, active-low: 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111, 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
  - dp = ~snapDP[k].
- Dark digit (EN=0, or snapBLINK[k]=1 with blink phase=1): DISP = all ones.
- EN does not stop counters or pointer. Re-enabling resumes at the current scan position.
- First frame after reset shows snapshot zeros ("0" on every digit, dp off).
- Input changes between FRAME pulses have no visible effect until the next frame.
- NUM_DIGITS=1: the pointer is constant 0, and FRAME/snapshot fire every DIGIT_TICKS cycles.

Optional Feature:
SEG7_LEADING_ZERO_BLANK_EN
- Defined: digit k>0 is dark (DISP all ones, dp included) when snapVALUE nibbles k..NUM_DIGITS-1 are all zero. Digit 0 is never blanked by this rule.
- Undefined: every digit is displayed, including leading zeros.

Decomposition:
- Package seg7_pkg holds:
  - 7-bit active-low hex segment constants and a nibble→segment function.
  - DISP field offsets (SEG_LSB=1, DP_BIT=0, AN_LSB=8).
  - DISP_OFF all-ones constant.
- Natural sub-module: seg7_hex_decoder, combinational 4-bit→7-bit, using the package function.
- Counters, snapshot and output registers live in the top module.

Test Plan (NUM_DIGITS=4, DIGIT_TICKS=4, BLINK_FRAMES=2):
1. Reset: hold RST_N=0 → DISP=12'hFFF and FRAME=0. Release → first lit digit is 3, DISP=12'b0111_0000001_1.
2. Hex/DP: VALUE=16'h12AF, DP=4'b0010, EN=1. After the next FRAME:
   - digit3 = 0111_1001111_1
   - digit2 = 1011_0010010_1
   - digit1 = 1101_0001000_0
   - digit0 = 1110_0111000_1
3. Snapshot: change VALUE to 16'h0000 mid-frame → remaining digits of that frame still show 12AF; the change appears only after the next FRAME pulse.
4. Blink: BLINK=4'b0001 → digit0 slot shows 12'hFFF during frames with phase=1 (2-3, 6-7 after snapshot) and is normal otherwise. Other digits are unaffected.
5. Enable/reset: EN=0 → DISP=12'hFFF one cycle later, and FRAME keeps pulsing every 16 cycles. Assert RST_N low mid-digit → DISP=12'hFFF with no clock edge.
6. With SEG7_LEADING_ZERO_BLANK_EN: VALUE=16'h0050 → digits 3 and 2 are dark, digit1 shows 5, digit0 shows 0. VALUE=0 → only digit0 is lit, showing "0".

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: active-low hex glyphs and DISP field layout.
// Latency: n/a (constants and a pure combinational helper function).
// Backpressure: none; compile-time definitions only.
package seg7_pkg;

  // DISP bus layout: {anodes, a..g, dp}
  localparam int DP_BIT  = 0;
  localparam int SEG_LSB = 1;
  localparam int AN_LSB  = 8;

  // Widest DISP bus (8 digits + 8 segment/dp bits); slice down to the real width
  localparam int DISP_MAX_W = 16;
  localparam logic [DISP_MAX_W-1:0] DISP_OFF = '1;

  // Active-low segment patterns, bit 6 = a ... bit 0 = g
  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  // Nibble to active-low segment pattern
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = SEG_0;
      4'h1:    seg = SEG_1;
      4'h2:    seg = SEG_2;
      4'h3:    seg = SEG_3;
      4'h4:    seg = SEG_4;
      4'h5:    seg = SEG_5;
      4'h6:    seg = SEG_6;
      4'h7:    seg = SEG_7;
      4'h8:    seg = SEG_8;
      4'h9:    seg = SEG_9;
      4'hA:    seg = SEG_A;
      4'hB:    seg = SEG_B;
      4'hC:    seg = SEG_C;
      4'hD:    seg = SEG_D;
      4'hE:    seg = SEG_E;
      default: seg = SEG_F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex nibble to active-low a..g segment decoder.
// Latency: 0 cycles (pure combinational).
// Backpressure: none.
module seg7_hex_decoder
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = hex_to_seg(nibble);

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit common-anode 7-seg driver; per-frame input snapshot, DP, blink, enable.
// Latency: DISP is registered, 1 cycle after pointer/snapshot/phase/EN; FRAME pulses on the frame wrap.
// Backpressure: none, free-running scan. Optional SEG7_LEADING_ZERO_BLANK_EN blanks leading zero digits.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS   = 4,
  parameter int DIGIT_TICKS  = 100000,
  parameter int BLINK_FRAMES = 250
) (
  input  logic                    CLK,
  input  logic                    RST_N,
  input  logic                    EN,
  input  logic [4*NUM_DIGITS-1:0] VALUE,
  input  logic [NUM_DIGITS-1:0]   DP,
  input  logic [NUM_DIGITS-1:0]   BLINK,
  output logic [NUM_DIGITS+7:0]   DISP,
  output logic                    FRAME
);

  localparam int DW = NUM_DIGITS + 8;
  localparam int PW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int TW = $clog2(DIGIT_TICKS);
  localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [PW-1:0] PTR_TOP   = PW'(NUM_DIGITS - 1);
  localparam logic [TW-1:0] TICK_TOP  = TW'(DIGIT_TICKS - 1);
  localparam logic [BW-1:0] BLINK_TOP = BW'(BLINK_FRAMES - 1);

  logic [TW-1:0]           tick;
  logic [PW-1:0]           ptr;
  logic                    tick_end;
  logic                    frame_wrap;
  logic [4*NUM_DIGITS-1:0] snap_value;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blink;
  logic [BW-1:0]           blink_cnt;
  logic                    blink_phase;
  logic [3:0]              cur_nibble;
  logic [6:0]              cur_seg;
  logic [NUM_DIGITS-1:0]   lz_dark;
  logic                    dark;
  logic [DW-1:0]           disp_nxt;

  assign tick_end   = (tick == TICK_TOP);
  assign frame_wrap = tick_end && (ptr == '0);

  // Digit dwell counter and scan pointer, leftmost digit first
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick <= '0;
      ptr  <= PTR_TOP;
    end else if (tick_end) begin
      tick <= '0;
      ptr  <= (ptr == '0) ? PTR_TOP : ptr - PW'(1);
    end else begin
      tick <= tick + TW'(1);
    end
  end

  // Frame boundary: capture inputs, pulse FRAME, advance blink timebase
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      snap_value  <= '0;
      snap_dp     <= '0;
      snap_blink  <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      FRAME       <= 1'b0;
    end else begin
      FRAME <= frame_wrap;
      if (frame_wrap) begin
        snap_value <= VALUE;
        snap_dp    <= DP;
        snap_blink <= BLINK;
        if (blink_cnt == BLINK_TOP) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BW'(1);
        end
      end
    end
  end

  // Only the currently scanned digit needs decoding
  assign cur_nibble = snap_value[{ptr, 2'b00} +: 4];

  seg7_hex_decoder u_hex_decoder (
    .nibble (cur_nibble),
    .seg    (cur_seg)
  );

`ifdef SEG7_LEADING_ZERO_BLANK_EN
  logic lz_run;

  // Digit k is a leading zero when it and every digit to its left are zero; digit 0 always shows
  always_comb begin
    lz_dark = '0;
    lz_run  = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      lz_run     = lz_run & (snap_value[4*k +: 4] == 4'd0);
      lz_dark[k] = lz_run;
    end
  end
`else
  assign lz_dark = '0;
`endif

  assign dark = !EN || (snap_blink[ptr] && blink_phase) || lz_dark[ptr];

  // Next display word: one anode low, glyph and dp for that digit, or all dark
  always_comb begin
    disp_nxt = DISP_OFF[DW-1:0];
    if (!dark) begin
      for (int k = 0; k < NUM_DIGITS; k++) begin
        disp_nxt[AN_LSB + k] = (ptr != PW'(k));
      end
      disp_nxt[SEG_LSB +: 7] = cur_seg;
      disp_nxt[DP_BIT]       = ~snap_dp[ptr];
    end
  end

  // Registered pin drive so the board sees glitch-free outputs
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      DISP <= DISP_OFF[DW-1:0];
    end else begin
      DISP <= disp_nxt;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: directed and random inputs against a cycle-count based display model.
// Latency: expected words are queued per clock edge and popped by an independent monitor.
// Backpressure: none; the DUT produces one DISP/FRAME word every cycle.
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int T  = 4;
  localparam int BF = 2;
  localparam int TN = N * T;
  localparam int DW = N + 8;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b1;
  logic          en    = 1'b0;
  logic [4*N-1:0] value = '0;
  logic [N-1:0]  dp    = '0;
  logic [N-1:0]  blink = '0;
  logic [DW-1:0] disp;
  logic          frame;

  seg7_scan_driver #(
    .NUM_DIGITS   (N),
    .DIGIT_TICKS  (T),
    .BLINK_FRAMES (BF)
  ) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .EN    (en),
    .VALUE (value),
    .DP    (dp),
    .BLINK (blink),
    .DISP  (disp),
    .FRAME (frame)
  );

  always #5 clk = ~clk;

  typedef struct {
    int            c;
    logic [DW-1:0] disp;
    logic          frame;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;

  logic [6:0]     seg_tab [16];
  logic [4*N-1:0] m_v;
  logic [N-1:0]   m_dp;
  logic [N-1:0]   m_bl;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
    end
  endtask

  // Expected DISP for scan state s (cycles since reset), from the display rules directly
  function automatic logic [DW-1:0] model_disp(input int s, input logic en_now);
    int            f;
    int            d;
    logic          phase;
    logic [DW-1:0] r;
    f     = s / TN;
    d     = N - 1 - (s % TN) / T;
    phase = ((f / BF) % 2) == 1;
    r     = '1;
    if (!en_now) return r;
    if (m_bl[d] && phase) return r;
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d > 0 && (m_v >> (4 * d)) == 0) return r;
`endif
    r[8 + d] = 1'b0;
    r[7:1]   = seg_tab[m_v[4*d +: 4]];
    r[0]     = ~m_dp[d];
    return r;
  endfunction

  // One clock: optionally randomize inputs, queue the expectation for the coming edge
  task automatic step(input bit rnd);
    exp_t e;
    if (rnd) begin
      if ($urandom_range(0, 5) == 0)  value = (4*N)'($urandom);
      if ($urandom_range(0, 7) == 0)  dp    = N'($urandom);
      if ($urandom_range(0, 9) == 0)  blink = N'($urandom);
      if ($urandom_range(0, 15) == 0) en    = ~en;
    end
    e.c     = cyc + 1;
    e.disp  = model_disp(cyc, en);
    e.frame = ((cyc + 1) % TN) == 0;
    q.push_back(e);
    if (((cyc + 1) % TN) == 0) begin
      m_v  = value;
      m_dp = dp;
      m_bl = blink;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    q.delete();
    #1;
    check("async_reset_disp", disp, '1);
    check("async_reset_frame", DW'(frame), '0);
    repeat (3) @(posedge clk);
    #1;
    check("held_reset_disp", disp, '1);
    check("held_reset_frame", DW'(frame), '0);
    m_v  = '0;
    m_dp = '0;
    m_bl = '0;
    cyc  = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: compare every DUT output word against the queued expectation for that edge
  initial begin
    forever begin
      @(negedge clk);
      while (q.size() > 0 && q[0].c <= cyc) begin
        mon_e = q.pop_front();
        check("disp", disp, mon_e.disp);
        check("frame", DW'(frame), DW'(mon_e.frame));
      end
    end
  end

  initial begin
    seg_tab = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};
    m_v  = '0;
    m_dp = '0;
    m_bl = '0;

    #1 rst_n = 1'b0;
    #1;
    check("reset_disp_noclk", disp, '1);
    check("reset_frame_noclk", DW'(frame), '0);
    repeat (2) @(posedge clk);
    #1;
    check("reset_disp_clk", disp, '1);
    check("reset_frame_clk", DW'(frame), '0);

    value = 16'h12AF;
    dp    = 4'b0010;
    blink = 4'b0000;
    en    = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;

    // Zeros frame, then 12AF with dp on digit 1
    repeat (3 * TN) step(0);
    // Mid-frame change must wait for the next frame
    repeat (TN / 2) step(0);
    value = 16'h0000;
    repeat (2 * TN) step(0);
    // Blink digit 0 across both phases
    value = 16'h12AF;
    blink = 4'b0001;
    repeat (9 * TN) step(0);
    blink = 4'b0000;
    // Leading-zero patterns
    value = 16'h0050;
    repeat (3 * TN) step(0);
    value = 16'h0000;
    repeat (3 * TN) step(0);
    // Disabled: dark but scan and FRAME keep running
    value = 16'hBEEF;
    dp    = 4'b1111;
    repeat (TN + 3) step(0);
    en = 1'b0;
    repeat (2 * TN) step(0);
    en = 1'b1;
    repeat (TN) step(0);

    repeat (60 * TN) step(1);

    do_reset();
    en = 1'b1;
    repeat (20 * TN) step(1);

    @(negedge clk);
    #1;
    check("queue_drained", DW'(q.size()), '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
